// File: rtl/doublepulse_sequencer_pkg.sv
// rtl/doublepulse_sequencer_pkg.sv - shared state encodings for the double-pulse sequencer
package doublepulse_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_RUN      = 2'd1;
    localparam state_t ST_COOLDOWN = 2'd2;

endpackage

// File: rtl/doublepulse_sequencer_oneshot_counter.sv
// rtl/doublepulse_sequencer_oneshot_counter.sv - saturating one-shot counter, parked at all-ones when idle
module oneshot_counter #(
    parameter int bitwidth = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                park,
    input  logic                enable,
    input  logic [bitwidth-1:0] limit,
    output logic [bitwidth-1:0] count,
    output logic                at_limit
);

    // Park value is all-ones so the downstream gate sees no pulse window.
    always_ff @(posedge clock) begin
        if (reset || park) begin
            count <= '1;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count < limit)) begin
            count <= count + bitwidth'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/doublepulse_sequencer.sv
// rtl/doublepulse_sequencer.sv - start-triggered prescaled one-shot counter with tick shadowing and cooldown
module doublepulse_sequencer
    import doublepulse_sequencer_pkg::*;
#(
    parameter int bitwidth       = 32,
    parameter int prescale_width = 16,
    parameter int cooldown_width = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [prescale_width-1:0] prescale,
    input  logic [cooldown_width-1:0] cooldown_ticks,
    input  logic [bitwidth-1:0]       tick_on1,
    input  logic [bitwidth-1:0]       tick_off1,
    input  logic [bitwidth-1:0]       tick_on2,
    input  logic [bitwidth-1:0]       tick_off2,
    input  logic [bitwidth-1:0]       tick_end,
    output logic [bitwidth-1:0]       counter,
    output logic [bitwidth-1:0]       tick_on1_q,
    output logic [bitwidth-1:0]       tick_off1_q,
    output logic [bitwidth-1:0]       tick_on2_q,
    output logic [bitwidth-1:0]       tick_off2_q,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic                      start_rejected,
    output logic                      config_error
);

    state_t                    state;
    logic                      start_d;
    logic                      start_edge;
    logic                      cfg_valid;
    logic                      accept;
    logic                      in_run;
    logic                      wrap;
    logic                      cnt_at_end;
    logic                      cnt_park;
    logic                      cnt_enable;
    logic [bitwidth-1:0]       end_q;
    logic [prescale_width-1:0] prescale_q;
    logic [prescale_width-1:0] pre_cnt;
    logic [cooldown_width-1:0] cooldown_q;
    logic [cooldown_width-1:0] cool_cnt;

    assign start_edge = start & ~start_d;
    assign cfg_valid  = (tick_on1 < tick_off1) && (tick_off1 <= tick_on2) &&
                        (tick_on2 < tick_off2) && (tick_off2 <= tick_end) &&
                        (tick_end != '1);
    assign accept     = (state == ST_IDLE) && start_edge && cfg_valid;
    assign in_run     = (state == ST_RUN);
    assign wrap       = (pre_cnt == prescale_q);
    // The final value is held for a full prescale period before the shot ends.
    assign cnt_park   = in_run && (abort || (wrap && cnt_at_end));
    assign cnt_enable = in_run && wrap;
    assign busy       = (state == ST_RUN) || (state == ST_COOLDOWN);

    oneshot_counter #(
        .bitwidth(bitwidth)
    ) u_count (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .park     (cnt_park),
        .enable   (cnt_enable),
        .limit    (end_q),
        .count    (counter),
        .at_limit (cnt_at_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            start_d        <= start;
            end_q          <= '0;
            prescale_q     <= '0;
            cooldown_q     <= '0;
            pre_cnt        <= '0;
            cool_cnt       <= '0;
            tick_on1_q     <= '0;
            tick_off1_q    <= '0;
            tick_on2_q     <= '0;
            tick_off2_q    <= '0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            start_rejected <= 1'b0;
            config_error   <= 1'b0;
        end else begin
            start_d        <= start;
            done           <= 1'b0;
            aborted        <= 1'b0;
            start_rejected <= start_edge && !accept;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        if (cfg_valid) begin
                            state        <= ST_RUN;
                            pre_cnt      <= '0;
                            end_q        <= tick_end;
                            prescale_q   <= prescale;
                            cooldown_q   <= cooldown_ticks;
                            tick_on1_q   <= tick_on1;
                            tick_off1_q  <= tick_off1;
                            tick_on2_q   <= tick_on2;
                            tick_off2_q  <= tick_off2;
                            config_error <= 1'b0;
                        end else begin
                            config_error <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_COOLDOWN;
                        cool_cnt <= cooldown_q;
                        aborted  <= 1'b1;
                    end else if (wrap) begin
                        pre_cnt <= '0;
                        if (cnt_at_end) begin
                            state    <= ST_COOLDOWN;
                            cool_cnt <= cooldown_q;
                            done     <= 1'b1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + prescale_width'(1);
                    end
                end
                ST_COOLDOWN: begin
                    // A zero cooldown still spends one cycle here.
                    if (cool_cnt <= cooldown_width'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - cooldown_width'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
